// File: rtl/pulse_generator.sv
// Turns (index, trigger) commands into a one-hot pulse of programmable length
// followed by an optional forced-low gap, with a single pending-command slot.
module pulse_generator #(
  parameter int PULSE_COUNT = 4,
  parameter int LEN_BITS    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             index,
  input  logic                   trigger,
  input  logic [LEN_BITS-1:0]    length,
  input  logic [LEN_BITS-1:0]    gap,
  output logic [PULSE_COUNT-1:0] pulses,
  output logic                   busy,
  output logic                   invalid,
  output logic                   overflow,
  output logic [15:0]            count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [LEN_BITS-1:0] LEN_ONE   = 1;
  localparam logic [8:0]          INDEX_LIM = 9'(PULSE_COUNT);

  // Command capture stage: the FSM acts on the command one edge after trigger.
  logic                cmd_valid_reg;
  logic [7:0]          cmd_index_reg;
  logic [LEN_BITS-1:0] cmd_len_reg;
  logic [LEN_BITS-1:0] cmd_gap_reg;

  state_t              state_reg, state_next;
  logic [LEN_BITS-1:0] cnt_reg, cnt_next;
  logic [7:0]          cur_index_reg, cur_index_next;
  logic [LEN_BITS-1:0] cur_gap_reg, cur_gap_next;

  logic                pend_valid_reg, pend_valid_next;
  logic [7:0]          pend_index_reg, pend_index_next;
  logic [LEN_BITS-1:0] pend_len_reg, pend_len_next;
  logic [LEN_BITS-1:0] pend_gap_reg, pend_gap_next;

  logic [PULSE_COUNT-1:0] pulses_reg, pulses_next;
  logic                   busy_reg, busy_next;
  logic                   invalid_reg, invalid_next;
  logic                   overflow_reg, overflow_next;
  logic [15:0]            count_reg, count_next;

  logic                   cmd_ok;
  logic                   cmd_bad;
  logic [LEN_BITS-1:0]    cmd_len_eff;
  logic                   load_pend;
  logic                   load_cmd;
  logic                   start;
  logic [PULSE_COUNT-1:0] onehot;

  assign cmd_ok      = cmd_valid_reg & ({1'b0, cmd_index_reg} < INDEX_LIM);
  assign cmd_bad     = cmd_valid_reg & ~({1'b0, cmd_index_reg} < INDEX_LIM);
  assign cmd_len_eff = (cmd_len_reg == '0) ? LEN_ONE : cmd_len_reg;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid_reg  <= 1'b0;
      cmd_index_reg  <= '0;
      cmd_len_reg    <= '0;
      cmd_gap_reg    <= '0;
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      cur_index_reg  <= '0;
      cur_gap_reg    <= '0;
      pend_valid_reg <= 1'b0;
      pend_index_reg <= '0;
      pend_len_reg   <= '0;
      pend_gap_reg   <= '0;
      pulses_reg     <= '0;
      busy_reg       <= 1'b0;
      invalid_reg    <= 1'b0;
      overflow_reg   <= 1'b0;
      count_reg      <= '0;
    end else begin
      cmd_valid_reg  <= trigger;
      cmd_index_reg  <= index;
      cmd_len_reg    <= length;
      cmd_gap_reg    <= gap;
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      cur_index_reg  <= cur_index_next;
      cur_gap_reg    <= cur_gap_next;
      pend_valid_reg <= pend_valid_next;
      pend_index_reg <= pend_index_next;
      pend_len_reg   <= pend_len_next;
      pend_gap_reg   <= pend_gap_next;
      pulses_reg     <= pulses_next;
      busy_reg       <= busy_next;
      invalid_reg    <= invalid_next;
      overflow_reg   <= overflow_next;
      count_reg      <= count_next;
    end
  end

  // Next-state logic, including pending-slot management
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    cur_index_next  = cur_index_reg;
    cur_gap_next    = cur_gap_reg;
    pend_valid_next = pend_valid_reg;
    pend_index_next = pend_index_reg;
    pend_len_next   = pend_len_reg;
    pend_gap_next   = pend_gap_reg;
    overflow_next   = 1'b0;
    load_pend       = 1'b0;
    load_cmd        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // A pending command can only be waiting here if it arrived on the
        // very edge the previous pulse/gap finished.
        if (pend_valid_reg) begin
          load_pend = 1'b1;
        end else if (cmd_ok) begin
          load_cmd = 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_reg == '0) begin
          if (cur_gap_reg != '0) begin
            state_next = S_GAP;
            cnt_next   = cur_gap_reg - LEN_ONE;
          end else if (pend_valid_reg) begin
            load_pend = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - LEN_ONE;
        end
      end
      S_GAP: begin
        if (cnt_reg == '0) begin
          if (pend_valid_reg) begin
            load_pend = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - LEN_ONE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (load_pend) begin
      state_next      = S_PULSE;
      cur_index_next  = pend_index_reg;
      cnt_next        = pend_len_reg - LEN_ONE;
      cur_gap_next    = pend_gap_reg;
      pend_valid_next = 1'b0;
    end

    if (load_cmd) begin
      state_next     = S_PULSE;
      cur_index_next = cmd_index_reg;
      cnt_next       = cmd_len_eff - LEN_ONE;
      cur_gap_next   = cmd_gap_reg;
    end

    // A slot freed on this same edge is immediately reusable.
    if (cmd_ok && !load_cmd) begin
      if (!pend_valid_reg || load_pend) begin
        pend_valid_next = 1'b1;
        pend_index_next = cmd_index_reg;
        pend_len_next   = cmd_len_eff;
        pend_gap_next   = cmd_gap_reg;
      end else begin
        overflow_next = 1'b1;
      end
    end
  end

  assign start = load_pend | load_cmd;

  generate
    for (genvar gi = 0; gi < PULSE_COUNT; gi++) begin : g_onehot
      assign onehot[gi] = (cur_index_next == 8'(gi));
    end
  endgenerate

  // Output logic (values registered alongside the state)
  always_comb begin
    pulses_next  = (state_next == S_PULSE) ? onehot : '0;
    busy_next    = (state_next != S_IDLE) | pend_valid_next;
    invalid_next = cmd_bad;
    count_next   = count_reg + 16'(start);
  end

  assign pulses   = pulses_reg;
  assign busy     = busy_reg;
  assign invalid  = invalid_reg;
  assign overflow = overflow_reg;
  assign count    = count_reg;

endmodule

// File: tb/tb_pulse_generator.sv
// Directed bench for pulse_generator: each task drives one scenario and checks
// pulses/busy/strobes/count cycle by cycle against hand-derived values.
module tb_pulse_generator;

  logic       clk;
  logic       rst;
  logic [7:0] index;
  logic       trigger;
  logic [7:0] length;
  logic [7:0] gap;
  logic [3:0] pulses;
  logic       busy;
  logic       invalid;
  logic       overflow;
  logic [15:0] count;

  int n_vec;
  int n_miss;
  logic [15:0] exp_count;

  pulse_generator #(.PULSE_COUNT(4), .LEN_BITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .index(index),
    .trigger(trigger),
    .length(length),
    .gap(gap),
    .pulses(pulses),
    .busy(busy),
    .invalid(invalid),
    .overflow(overflow),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic t, input logic [7:0] i, input logic [7:0] l, input logic [7:0] g);
    trigger = t;
    index   = i;
    length  = l;
    gap     = g;
  endtask

  task automatic test_reset();
    logic [3:0] exp_p;
    rst = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    repeat (3) step();
    n_vec++;
    if (pulses !== 4'b0000 || busy !== 1'b0 || invalid !== 1'b0 || overflow !== 1'b0 || count !== 16'h0000) begin
      n_miss++;
      $display("FAIL reset_state: pulses=%b busy=%b inv=%b ovf=%b count=%h, required 0000/0/0/0/0000",
               pulses, busy, invalid, overflow, count);
    end
    rst = 1'b0;
    step();

    // Start a long pulse, then hit reset between clock edges.
    drive(1'b1, 8'd1, 8'd10, 8'd0);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    step();
    n_vec++;
    if (pulses !== 4'b0010 || count !== 16'h0001) begin
      n_miss++;
      $display("FAIL reset_prepulse: pulses=%b count=%h, required 0010/0001", pulses, count);
    end
    step();
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (pulses !== 4'b0000 || busy !== 1'b0 || count !== 16'h0000) begin
      n_miss++;
      $display("FAIL reset_async: pulses=%b busy=%b count=%h, required 0000/0/0000", pulses, busy, count);
    end
    step();
    rst = 1'b0;
    step();
    exp_count = 16'h0000;

    drive(1'b1, 8'd2, 8'd3, 8'd0);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    exp_count = exp_count + 16'd1;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_p = (k <= 3) ? 4'b0100 : 4'b0000;
      n_vec++;
      if (pulses !== exp_p || busy !== (k <= 3) || count !== exp_count) begin
        n_miss++;
        $display("FAIL reset_first_pulse k=%0d: pulses=%b busy=%b count=%h, required %b/%b/%h",
                 k, pulses, busy, count, exp_p, (k <= 3), exp_count);
      end
    end
    $display("test_reset: idx=2 len=3 gap=0 done, count=%h", count);
  endtask

  task automatic test_length_zero();
    logic [3:0] exp_p;
    drive(1'b1, 8'd0, 8'd0, 8'd0);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    exp_count = exp_count + 16'd1;
    for (int k = 1; k <= 3; k++) begin
      step();
      exp_p = (k == 1) ? 4'b0001 : 4'b0000;
      n_vec++;
      if (pulses !== exp_p || busy !== (k == 1) || count !== exp_count) begin
        n_miss++;
        $display("FAIL length_zero k=%0d: pulses=%b busy=%b count=%h, required %b/%b/%h",
                 k, pulses, busy, count, exp_p, (k == 1), exp_count);
      end
    end
    $display("test_length_zero: idx=0 len=0 done, count=%h", count);
  endtask

  task automatic test_pending_gap();
    logic [3:0] exp_p;
    logic       exp_b;
    drive(1'b1, 8'd1, 8'd2, 8'd3);
    step();
    drive(1'b1, 8'd3, 8'd1, 8'd0);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    // Already one edge past the first command: k counts edges after its capture.
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) step();
      if (k == 1) exp_count = exp_count + 16'd1;
      if (k == 6) exp_count = exp_count + 16'd1;
      exp_p = (k <= 2) ? 4'b0010 : (k == 6) ? 4'b1000 : 4'b0000;
      exp_b = (k <= 6);
      n_vec++;
      if (pulses !== exp_p || busy !== exp_b || count !== exp_count) begin
        n_miss++;
        $display("FAIL pending_gap k=%0d: pulses=%b busy=%b count=%h, required %b/%b/%h",
                 k, pulses, busy, count, exp_p, exp_b, exp_count);
      end
    end
    $display("test_pending_gap: idx1 L2 G3 then idx3 L1 G0 done, count=%h", count);
  endtask

  task automatic test_overflow();
    logic [3:0] exp_p;
    int         seen2;
    seen2 = 0;
    for (int k = 0; k <= 12; k++) begin
      drive(k < 3, 8'(k), 8'd5, 8'd0);
      step();
      if (k == 1 || k == 6) exp_count = exp_count + 16'd1;
      exp_p = (k >= 1 && k <= 5) ? 4'b0001 : (k >= 6 && k <= 10) ? 4'b0010 : 4'b0000;
      if (pulses[2]) seen2++;
      n_vec++;
      if (pulses !== exp_p || overflow !== (k == 3) || count !== exp_count) begin
        n_miss++;
        $display("FAIL overflow k=%0d: pulses=%b ovf=%b count=%h, required %b/%b/%h",
                 k, pulses, overflow, count, exp_p, (k == 3), exp_count);
      end
    end
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    n_vec++;
    if (seen2 != 0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL overflow_drop: line2 cycles=%0d busy=%b, required 0/0", seen2, busy);
    end
    $display("test_overflow: 3 triggers L=5, third dropped, count=%h", count);
  endtask

  task automatic test_invalid();
    drive(1'b1, 8'd4, 8'd3, 8'd0);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      n_vec++;
      if (invalid !== (k == 1) || pulses !== 4'b0000 || busy !== 1'b0 || count !== exp_count) begin
        n_miss++;
        $display("FAIL invalid k=%0d: inv=%b pulses=%b busy=%b count=%h, required %b/0000/0/%h",
                 k, invalid, pulses, busy, count, (k == 1), exp_count);
      end
    end
    $display("test_invalid: idx=4 rejected, count=%h", count);
  endtask

  task automatic test_wrap_merge();
    int burst;
    int ovf_seen;
    logic exp_hi;
    // Back-to-back L=1 commands run at one per cycle, bringing count to 0xFFFE.
    burst    = 16'hFFFE - int'(exp_count);
    ovf_seen = 0;
    for (int i = 0; i < burst; i++) begin
      drive(1'b1, 8'(i % 4), 8'd1, 8'd0);
      step();
      if (overflow === 1'b1 || invalid === 1'b1) ovf_seen++;
    end
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    repeat (5) begin
      step();
      if (overflow === 1'b1 || invalid === 1'b1) ovf_seen++;
    end
    exp_count = 16'hFFFE;
    n_vec++;
    if (ovf_seen != 0 || busy !== 1'b0 || count !== exp_count) begin
      n_miss++;
      $display("FAIL burst: strobes=%0d busy=%b count=%h, required 0/0/%h", ovf_seen, busy, count, exp_count);
    end
    $display("test_wrap_merge: burst of %0d commands, count=%h", burst, count);

    drive(1'b1, 8'd0, 8'd2, 8'd0);
    step();
    drive(1'b1, 8'd0, 8'd2, 8'd0);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) step();
      if (k == 1) exp_count = 16'hFFFF;
      if (k == 3) exp_count = 16'h0000;
      exp_hi = (k <= 4);
      n_vec++;
      if (pulses !== {3'b000, exp_hi} || count !== exp_count) begin
        n_miss++;
        $display("FAIL merge k=%0d: pulses=%b count=%h, required %b/%h",
                 k, pulses, count, {3'b000, exp_hi}, exp_count);
      end
    end
    $display("test_wrap_merge: merged idx0 pulses done, count=%h", count);
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    exp_count = 16'h0000;
    rst       = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    test_reset();
    test_length_zero();
    test_pending_gap();
    test_overflow();
    test_invalid();
    test_wrap_merge();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
